// File: rtl/proc_pkg.sv
// Shared types, sizes and helpers for the register-file transfer sequencer.
package proc_pkg;

    localparam int unsigned N_SEL   = 8;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned SEL_IMM = 5;

    // Encoding of the last_grant flop: which requester won the previous arbitration.
    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StWrite,
        StErr,
        StGap
    } xfer_state_e;

    // Index to one-hot select vector.
    function automatic logic [N_SEL-1:0] onehot_dec(input logic [SEL_W-1:0] idx);
        logic [N_SEL-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/reg_xfer_ctrl_if.sv
// Requester/select bundle between the two requesters, the sequencer and the register file.
interface reg_xfer_ctrl_if #(
    parameter int unsigned N_SEL = proc_pkg::N_SEL,
    parameter int unsigned SEL_W = proc_pkg::SEL_W
);
    logic             req_a;
    logic [SEL_W-1:0] src_a;
    logic [SEL_W-1:0] dst_a;
    logic             ack_a;
    logic             req_b;
    logic [SEL_W-1:0] src_b;
    logic [SEL_W-1:0] dst_b;
    logic             ack_b;
    logic [N_SEL-1:0] rs;
    logic [N_SEL-1:0] ws;
    logic             err;
    logic             busy;

    // Requester side: issues transfers, observes completion and strobes.
    modport master (
        output req_a, src_a, dst_a, req_b, src_b, dst_b,
        input  ack_a, ack_b, rs, ws, err, busy
    );

    // Sequencer side.
    modport slave (
        input  req_a, src_a, dst_a, req_b, src_b, dst_b,
        output ack_a, ack_b, rs, ws, err, busy
    );
endinterface

// File: rtl/reg_xfer_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter; combinational, the last_grant flop lives in the caller.
module rr_arbiter2
    import proc_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic gnt_a,
    output logic gnt_b
);

    // A lone requester always wins; on a tie the one not granted last wins.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && req_b) begin
            gnt_a = (last_grant == GRANT_B);
            gnt_b = (last_grant == GRANT_A);
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end
    end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Bus-transfer sequencer: arbitrates two requesters and turns each src->dst transfer into
// timed one-hot read/write select strobes with a turnaround gap between transfers.
module reg_xfer_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned N_SEL   = proc_pkg::N_SEL,
    parameter int unsigned SEL_W   = proc_pkg::SEL_W,
    parameter int unsigned SEL_IMM = proc_pkg::SEL_IMM
) (
    input  logic            clk,
    input  logic            rst,
    reg_xfer_ctrl_if.slave  bus
);

    xfer_state_e      state_q, state_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] dst_q, dst_d;
    logic             owner_q, owner_d;       // requester currently being served
    logic             last_grant_q, last_grant_d;

    logic [N_SEL-1:0] rs_q, rs_d;
    logic [N_SEL-1:0] ws_q, ws_d;
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             gnt_a, gnt_b;
    logic             legal;

    rr_arbiter2 u_arb (
        .req_a      (bus.req_a),
        .req_b      (bus.req_b),
        .last_grant (last_grant_q),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b)
    );

    // Legality of the indices being latched this cycle; only consulted in IDLE.
    assign legal = (src_d != dst_d) && (dst_d != SEL_W'(SEL_IMM));

    // Next state, index latch and grant bookkeeping.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_a || gnt_b) begin
                    owner_d      = gnt_b ? GRANT_B : GRANT_A;
                    last_grant_d = owner_d;
                    src_d        = gnt_b ? bus.src_b : bus.src_a;
                    dst_d        = gnt_b ? bus.dst_b : bus.dst_a;
                    state_d      = legal ? StDrive : StErr;
                end
            end
            StDrive: state_d = StWrite;
            StWrite: state_d = StGap;
            StErr:   state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the upcoming state so every strobe leaves a flop.
    always_comb begin
        rs_d    = '0;
        ws_d    = '0;
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
        err_d   = 1'b0;
        busy_d  = (state_d != StIdle);
        unique case (state_d)
            StDrive: begin
                rs_d = N_SEL'(onehot_dec(src_d));
            end
            StWrite: begin
                rs_d    = N_SEL'(onehot_dec(src_d));
                ws_d    = N_SEL'(onehot_dec(dst_d));
                ack_a_d = (owner_d == GRANT_A);
                ack_b_d = (owner_d == GRANT_B);
            end
            StErr: begin
                ack_a_d = (owner_d == GRANT_A);
                ack_b_d = (owner_d == GRANT_B);
                err_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset makes A win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            src_q        <= '0;
            dst_q        <= '0;
            owner_q      <= GRANT_A;
            last_grant_q <= GRANT_B;
            rs_q         <= '0;
            ws_q         <= '0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rs_q         <= rs_d;
            ws_q         <= ws_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.rs    = rs_q;
    assign bus.ws    = ws_q;
    assign bus.ack_a = ack_a_q;
    assign bus.ack_b = ack_b_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule
